// File: rtl/mem_inc_pkg.sv
// Shared types for the memory access path: request parameters, encodings
// and the access-unit state enum.
package mem_inc;

  typedef struct packed {
    logic       op;            // 1 = read, 0 = write
    logic [1:0] access_size;
    logic       read_unsigned;
  } mem_params_t;

  localparam logic       MEM_OP_READ    = 1'b1;
  localparam logic       MEM_OP_WRITE   = 1'b0;
  localparam logic [1:0] MEM_SIZE_BYTE  = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF  = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables, store replication, load
// shift/extend and the alignment/size legality check.
module mem_lane_align
  import mem_inc::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  access_size,
  input  logic        read_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        illegal
);

  logic [31:0] shifted;

  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'h0;
    rdata_ext = 32'h0;
    illegal   = 1'b0;
    shifted   = rdata >> {addr_lo, 3'b000};
    case (access_size)
      MEM_SIZE_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = read_unsigned ? {24'h0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      end
      MEM_SIZE_HALF: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = read_unsigned ? {16'h0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
        illegal   = addr_lo[0];
      end
      MEM_SIZE_WORD: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = shifted;
        illegal   = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store executor driving a word-addressed req/ack
// data bus, with alignment checks and an optional ack timeout.
//
//   state   | meaning
//   IDLE    | ready for a request
//   BUS     | bus_req asserted, waiting for bus_ack or timeout
//   RESP    | one-cycle resp_valid pulse
module mem_access_unit
  import mem_inc::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int TMO_W       = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  mem_params_t       req_params,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [31:0]       bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(ACK_TIMEOUT);

  mem_state_t       state_q, state_d;
  logic             op_q, op_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [1:0]       lo_q, lo_d;
  logic [TMO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic             resp_fault_q, resp_fault_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [3:0]       bus_be_q, bus_be_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;

  logic [1:0]  al_lo, al_size;
  logic        al_uns;
  logic [3:0]  al_be;
  logic [31:0] al_wrep, al_rext;
  logic        al_illegal;
  logic        idle;

  assign idle      = (state_q == ST_IDLE);
  assign req_ready = idle & reset_n;

  // Lane logic looks at the incoming request while idle, at the latched one otherwise.
  assign al_lo   = idle ? req_addr[1:0]           : lo_q;
  assign al_size = idle ? req_params.access_size  : size_q;
  assign al_uns  = idle ? req_params.read_unsigned : uns_q;

  mem_lane_align u_align (
    .addr_lo       (al_lo),
    .access_size   (al_size),
    .read_unsigned (al_uns),
    .wdata         (req_wdata),
    .rdata         (bus_rdata),
    .be            (al_be),
    .wdata_rep     (al_wrep),
    .rdata_ext     (al_rext),
    .illegal       (al_illegal)
  );

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    size_d       = size_q;
    uns_d        = uns_q;
    lo_d         = lo_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          op_d   = req_params.op;
          size_d = req_params.access_size;
          uns_d  = req_params.read_unsigned;
          lo_d   = req_addr[1:0];
          if (al_illegal) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            state_d     = ST_BUS;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = (req_params.op == MEM_OP_WRITE);
            bus_addr_d  = {req_addr[31:2], 2'b00};
            bus_be_d    = al_be;
            bus_wdata_d = al_wrep;
          end
        end
      end
      ST_BUS: begin
        if (bus_ack) begin
          state_d      = ST_RESP;
          bus_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b0;
          resp_rdata_d = (op_q == MEM_OP_READ) ? al_rext : 32'h0;
        end else begin
          cnt_d = cnt_inc;
          if (ACK_TIMEOUT != 0 && cnt_inc == TMO_LIM) begin
            state_d      = ST_RESP;
            bus_req_d    = 1'b0;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_rdata_d = 32'h0;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      op_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      lo_q         <= 2'b00;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_fault_q <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'h0;
      bus_be_q     <= 4'h0;
      bus_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      lo_q         <= lo_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, faults, timeout and
// reset-abort scenarios with hand-computed expectations.
module tb_mem_access_unit;
  import mem_inc::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  mem_params_t req_params = '0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ACK_TIMEOUT(16), .TMO_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_params(req_params),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; returns in the cycle after acceptance.
  task automatic issue(input logic op, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_params.op            = op;
    req_params.access_size   = sz;
    req_params.read_unsigned = uns;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step();
    tests++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", req_ready); end
    tests++; if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_be !== 4'h0) begin errors++; $display("FAIL reset_bus got req=%b we=%b be=%h exp 0", bus_req, bus_we, bus_be); end
    tests++; if (bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus_data got addr=%h wdata=%h exp 0", bus_addr, bus_wdata); end
    tests++; if (resp_valid !== 1'b0 || resp_fault !== 1'b0 || resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp got v=%b f=%b d=%h exp 0", resp_valid, resp_fault, resp_rdata); end
    reset_n = 1'b1;
    #1;
    tests++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_load_byte_signed();
    issue(MEM_OP_READ, MEM_SIZE_BYTE, 1'b0, 32'h0000_1003, 32'h0);
    tests++; if (bus_req !== 1'b1 || bus_we !== 1'b0) begin errors++; $display("FAIL lb_bus got req=%b we=%b exp req=1 we=0", bus_req, bus_we); end
    tests++; if (bus_addr !== 32'h0000_1000) begin errors++; $display("FAIL lb_addr got %h exp 00001000", bus_addr); end
    tests++; if (bus_be !== 4'b1000) begin errors++; $display("FAIL lb_be got %b exp 1000", bus_be); end
    tests++; if (req_ready !== 1'b0) begin errors++; $display("FAIL lb_busy_ready got %b exp 0", req_ready); end
    bus_ack = 1'b1; bus_rdata = 32'h80FF_1234;
    step();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    tests++; if (resp_valid !== 1'b1 || resp_fault !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL lb_resp got v=%b f=%b req=%b exp v=1 f=0 req=0", resp_valid, resp_fault, bus_req); end
    tests++; if (resp_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata got %h exp ffffff80", resp_rdata); end
    step();
    tests++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL lb_pulse got v=%b ready=%b exp v=0 ready=1", resp_valid, req_ready); end
    tests++; if (resp_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_hold got %h exp ffffff80", resp_rdata); end
  endtask

  task automatic test_load_half();
    // Unsigned, ack delayed two cycles: resp_valid must track the ack.
    issue(MEM_OP_READ, MEM_SIZE_HALF, 1'b1, 32'h0000_2002, 32'h0);
    tests++; if (bus_be !== 4'b1100 || bus_addr !== 32'h0000_2000) begin errors++; $display("FAIL lhu_bus got be=%b addr=%h exp be=1100 addr=00002000", bus_be, bus_addr); end
    step(); step();
    tests++; if (bus_req !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL lhu_wait got req=%b v=%b exp req=1 v=0", bus_req, resp_valid); end
    bus_ack = 1'b1; bus_rdata = 32'hBEEF_0000;
    step();
    bus_ack = 1'b0;
    tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_rdata got v=%b d=%h exp v=1 d=0000beef", resp_valid, resp_rdata); end
    step();
    issue(MEM_OP_READ, MEM_SIZE_HALF, 1'b0, 32'h0000_2002, 32'h0);
    bus_ack = 1'b1; bus_rdata = 32'hBEEF_0000;
    step();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_rdata got v=%b d=%h exp v=1 d=ffffbeef", resp_valid, resp_rdata); end
    step();
  endtask

  task automatic test_store_byte();
    issue(MEM_OP_WRITE, MEM_SIZE_BYTE, 1'b0, 32'h0000_3001, 32'h0000_00A5);
    tests++; if (bus_req !== 1'b1 || bus_we !== 1'b1) begin errors++; $display("FAIL sb_bus got req=%b we=%b exp 1 1", bus_req, bus_we); end
    tests++; if (bus_be !== 4'b0010 || bus_addr !== 32'h0000_3000) begin errors++; $display("FAIL sb_be got be=%b addr=%h exp be=0010 addr=00003000", bus_be, bus_addr); end
    tests++; if (bus_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata got %h exp a5a5a5a5", bus_wdata); end
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    step();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_fault !== 1'b0) begin errors++; $display("FAIL sb_resp got v=%b d=%h f=%b exp v=1 d=0 f=0", resp_valid, resp_rdata, resp_fault); end
    step();
    // Halfword store at upper lane.
    issue(MEM_OP_WRITE, MEM_SIZE_HALF, 1'b0, 32'h0000_3002, 32'h0000_C3D4);
    tests++; if (bus_be !== 4'b1100 || bus_wdata !== 32'hC3D4_C3D4) begin errors++; $display("FAIL sh_bus got be=%b wdata=%h exp be=1100 wdata=c3d4c3d4", bus_be, bus_wdata); end
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
  endtask

  task automatic test_faults();
    logic [1:0] sizes [3] = '{MEM_SIZE_WORD, 2'b11, MEM_SIZE_HALF};
    logic [31:0] addrs [3] = '{32'h0000_4002, 32'h0000_4000, 32'h0000_4001};
    for (int i = 0; i < 3; i++) begin
      issue(MEM_OP_READ, sizes[i], 1'b0, addrs[i], 32'h0);
      tests++; if (bus_req !== 1'b0) begin errors++; $display("FAIL fault_nobus[%0d] got req=%b exp 0", i, bus_req); end
      tests++; if (resp_valid !== 1'b1 || resp_fault !== 1'b1 || resp_rdata !== 32'h0) begin errors++; $display("FAIL fault_resp[%0d] got v=%b f=%b d=%h exp v=1 f=1 d=0", i, resp_valid, resp_fault, resp_rdata); end
      step();
      tests++; if (bus_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL fault_after[%0d] got req=%b v=%b ready=%b exp 0 0 1", i, bus_req, resp_valid, req_ready); end
    end
  endtask

  task automatic test_timeout();
    int hi_cycles = 0;
    bit done = 0;
    issue(MEM_OP_READ, MEM_SIZE_WORD, 1'b0, 32'h0000_5000, 32'h0);
    for (int c = 0; c < 40 && !done; c++) begin
      if (resp_valid) done = 1;
      else begin
        if (bus_req) hi_cycles++;
        step();
      end
    end
    tests++; if (!done) begin errors++; $display("FAIL tmo_wait got no resp_valid exp resp within 40 cycles"); end
    tests++; if (hi_cycles !== 16) begin errors++; $display("FAIL tmo_cycles got %0d exp 16", hi_cycles); end
    tests++; if (resp_fault !== 1'b1 || bus_req !== 1'b0 || resp_rdata !== 32'h0) begin errors++; $display("FAIL tmo_resp got f=%b req=%b d=%h exp f=1 req=0 d=0", resp_fault, bus_req, resp_rdata); end
    step();
    // Ack on the 16th BUS cycle wins over the timeout.
    issue(MEM_OP_READ, MEM_SIZE_WORD, 1'b0, 32'h0000_5004, 32'h0);
    for (int c = 0; c < 15; c++) step();
    tests++; if (bus_req !== 1'b1) begin errors++; $display("FAIL tmo16_req got %b exp 1", bus_req); end
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    step();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    tests++; if (resp_valid !== 1'b1 || resp_fault !== 1'b0 || resp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL tmo16_resp got v=%b f=%b d=%h exp v=1 f=0 d=12345678", resp_valid, resp_fault, resp_rdata); end
    step();
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    issue(MEM_OP_READ, MEM_SIZE_WORD, 1'b0, 32'h0000_6000, 32'h0);
    step(); step();
    tests++; if (bus_req !== 1'b1) begin errors++; $display("FAIL abort_bus3 got %b exp 1", bus_req); end
    reset_n = 1'b0;
    step();
    tests++; if (bus_req !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL abort_drop got req=%b v=%b exp 0 0", bus_req, resp_valid); end
    reset_n = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    #1;
    tests++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", req_ready); end
    step();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      if (resp_valid || bus_req) seen++;
      step();
    end
    tests++; if (seen !== 0) begin errors++; $display("FAIL abort_noresp got %0d active cycles exp 0", seen); end
  endtask

  task automatic test_back_to_back();
    issue(MEM_OP_WRITE, MEM_SIZE_WORD, 1'b0, 32'h0000_7000, 32'hDEAD_BEEF);
    tests++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_be !== 4'b1111 || bus_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_st got req=%b we=%b be=%b wd=%h exp 1 1 1111 deadbeef", bus_req, bus_we, bus_be, bus_wdata); end
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0) begin errors++; $display("FAIL b2b_st_resp got v=%b d=%h exp 1 0", resp_valid, resp_rdata); end
    step();
    issue(MEM_OP_READ, MEM_SIZE_BYTE, 1'b1, 32'h0000_7002, 32'h0);
    tests++; if (bus_be !== 4'b0100 || bus_we !== 1'b0) begin errors++; $display("FAIL b2b_ld_be got be=%b we=%b exp 0100 0", bus_be, bus_we); end
    bus_ack = 1'b1; bus_rdata = 32'h11F2_3344;
    step();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_00F2) begin errors++; $display("FAIL b2b_ld_rdata got v=%b d=%h exp 1 000000f2", resp_valid, resp_rdata); end
    step();
  endtask

  initial begin
    test_reset();
    test_load_byte_signed();
    test_load_half();
    test_store_byte();
    test_faults();
    test_timeout();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Responder/executor for the memory-request encoding produced by instruction decode (mem_params_t: op R/!W, access_size, read_unsigned).
- Accepts one load/store request at a time.
- Checks alignment.
- Drives a 32-bit word-addressed data bus with byte enables and a req/ack handshake.
- Returns load data aligned to bit 0 and sign- or zero-extended.
Sits between the execute stage and the data memory / bus fabric.

Parameters:
- ACK_TIMEOUT, 16: cycles to wait for bus_ack before aborting with a fault; 0 disables the timeout.
- TMO_W, 5: width of the timeout counter; must satisfy 2^TMO_W > ACK_TIMEOUT.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_params  in  mem_params_t  op (1=read, 0=write), access_size[1:0], read_unsigned
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores/faults)
- resp_fault  out  1  misaligned, illegal size, or bus timeout
- bus_req  out  1  bus transaction request
- bus_we  out  1  1=write
- bus_addr  out  32  word address, {req_addr[31:2],2'b00}
- bus_be  out  4  byte lane enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  transaction complete; bus_rdata valid in same cycle
- bus_rdata  in  32  raw read word

Behaviour:
- Clock and reset: one clock (clk); reset_n is synchronous and active-low.
- Reset values (reset_n low at an edge): state IDLE; resp_valid=0; resp_rdata=0; resp_fault=0; bus_req=0; bus_we=0; bus_addr=0; bus_be=0; bus_wdata=0; timeout counter 0.
- req_ready = (state==IDLE) & reset_n.
- FSM states:
  - IDLE: on req_valid&req_ready, register params, addr, wdata and lane info. Legal request -> BUS. Illegal request -> RESP with fault=1.
  - BUS: bus_req=1; bus_we, bus_addr, bus_be, bus_wdata held stable until exit.
    - bus_ack=1 -> capture the processed bus_rdata -> RESP.
    - Counter increments each BUS cycle without ack. When ACK_TIMEOUT!=0 and the counter reaches ACK_TIMEOUT: drop bus_req, fault=1 -> RESP.
    - An ack in the same cycle as the timeout wins; no fault.
  - RESP: resp_valid=1 for exactly one cycle -> IDLE.
- Latency:
  - Accept at edge N; bus_req high in cycle N+1.
  - Ack in cycle N+1+k; resp_valid in cycle N+2+k.
  - Fault without bus access: resp_valid in cycle N+1.
- Legality:
  - size 00 (byte): always legal.
  - size 01 (half): addr[0] must be 0.
  - size 10 (word): addr[1:0] must be 00.
  - size 11: illegal.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << {addr[1],1'b0}.
  - word: 4'b1111.
- Store data: byte replicated x4, half replicated x2, word as-is. bus_we=1 for stores.
- Load data:
  - Shift bus_rdata right by 8*addr[1:0].
  - byte: extend bit 7. half: extend bit 15.
  - read_unsigned=1 selects zero-extension.
  - word ignores read_unsigned.
- Stores and faulted requests return resp_rdata=0.
- Spurious bus_ack in IDLE or RESP is ignored.
- bus_rdata is sampled only on the accepting ack cycle.
- reset_n low while in BUS: bus_req drops at that edge. A later ack is ignored. No resp_valid is produced for the aborted request.
- resp_rdata and resp_fault hold their value after the pulse until the next response.

Decomposition:
- Package mem_inc: mem_params_t, MEM_OP_READ/MEM_OP_WRITE, MEM_SIZE_BYTE/HALF/WORD constants, mem_state_t enum.
- One combinational sub-module, mem_lane_align: generates byte enables, replicates store data, shifts and extends load data, and flags misalignment.
- The FSM, timeout counter and registers stay in mem_access_unit.

Test Plan:
- Load byte signed: addr 0x1003, bus_rdata 0x80FF_1234 -> bus_addr 0x1000, be 4'b1000, resp_rdata 0xFFFF_FF80, fault 0.
- Load half unsigned: addr 0x2002, bus_rdata 0xBEEF_0000 -> be 4'b1100, resp_rdata 0x0000_BEEF; same with read_unsigned=0 -> 0xFFFF_BEEF.
- Store byte: addr 0x3001, wdata 0x0000_00A5 -> bus_we 1, be 4'b0010, bus_wdata 0xA5A5_A5A5, resp_rdata 0.
- Misaligned word load at 0x4002 -> no bus_req ever asserted; resp_valid one cycle after accept, fault 1; size 11 gives the same result.
- Ack withheld with ACK_TIMEOUT=16 -> bus_req high 16 cycles then low, resp_fault 1; ack arriving on cycle 16 -> no fault.
- reset_n low in the 3rd BUS cycle, then ack -> bus_req 0 after edge, no resp_valid, req_ready 1 once reset_n returns high; a back-to-back request then proceeds normally.
